clint_mmio: RTL

//  Memory-mapped slave sitting directly upstream of the machine timer: decodes

---
 rtl/clint_mmio.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/clint_mmio.sv
// clint_mmio: word-addressed MMIO slave in front of the machine timer.
// Mirrors mtimecmp for readback, drives the timer's compare load port,
// snapshots mtime high on a low-word read for coherent 64-bit reads,
// and holds msip.
// Optional feature macro: CLINT_MSIP_EN (makes offset 0x00 a writable msip bit).
module clint_mmio #(
  parameter int unsigned ADDR_W  = 5,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ack,
  output logic              bus_err,
  input  logic [31:0]       mtime_h,
  input  logic [31:0]       mtime_l,
  output logic [31:0]       mtimecmp_in,
  output logic [1:0]        mtimecmp_set,
  output logic              msip
);

  localparam logic [ADDR_W-1:0] A_MSIP   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_CMP_LO = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_CMP_HI = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_MT_LO  = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_MT_HI  = ADDR_W'(32'h10);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] rdata_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] cmp_in_q;
  logic [1:0]  cmp_set_q;
  logic [63:0] mirror_q;
  logic [31:0] snap_q;

  logic        sel_msip;
  logic        sel_cmp_lo;
  logic        sel_cmp_hi;
  logic        sel_mt_lo;
  logic        sel_mt_hi;
  logic        err_d;
  logic [31:0] rdata_d;

  // Address decode and read-data mux for the access currently on the bus
  always_comb begin
    sel_msip   = 1'b0;
    sel_cmp_lo = 1'b0;
    sel_cmp_hi = 1'b0;
    sel_mt_lo  = 1'b0;
    sel_mt_hi  = 1'b0;
    rdata_d    = 32'h0;
    case (bus_addr)
      A_MSIP:   sel_msip   = 1'b1;
      A_CMP_LO: sel_cmp_lo = 1'b1;
      A_CMP_HI: sel_cmp_hi = 1'b1;
      A_MT_LO:  sel_mt_lo  = 1'b1;
      A_MT_HI:  sel_mt_hi  = 1'b1;
      default:  ;
    endcase
    // mtime words are read-only; a write to them is an error like an unmapped hit
    err_d = !(sel_msip || sel_cmp_lo || sel_cmp_hi || (!bus_we && (sel_mt_lo || sel_mt_hi)));
    if (sel_msip)   rdata_d = {31'b0, msip};
    if (sel_cmp_lo) rdata_d = mirror_q[31:0];
    if (sel_cmp_hi) rdata_d = mirror_q[63:32];
    if (sel_mt_lo)  rdata_d = mtime_l;
    if (sel_mt_hi)  rdata_d = snap_q;
  end

`ifdef CLINT_MSIP_EN
  logic msip_q;

  // Software interrupt bit, written only through an accepted 0x00 write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      msip_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus_req && bus_we && sel_msip) begin
      msip_q <= bus_wdata[0];
    end
  end

  assign msip = msip_q;
`else
  assign msip = 1'b0;
`endif

  // Two-state access FSM: accept in IDLE, respond for exactly one cycle in RESP
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      rdata_q   <= 32'h0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      cmp_in_q  <= 32'h0;
      cmp_set_q <= 2'b00;
      mirror_q  <= CMP_RST;
      snap_q    <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q     <= 1'b0;
          err_q     <= 1'b0;
          rdata_q   <= 32'h0;
          cmp_set_q <= 2'b00;
          if (bus_req) begin
            state_q <= ST_RESP;
            ack_q   <= 1'b1;
            err_q   <= err_d;
            if (!err_d) begin
              if (bus_we) begin
                if (sel_cmp_lo) begin
                  cmp_in_q        <= bus_wdata;
                  cmp_set_q       <= 2'b01;
                  mirror_q[31:0]  <= bus_wdata;
                end
                if (sel_cmp_hi) begin
                  cmp_in_q        <= bus_wdata;
                  cmp_set_q       <= 2'b10;
                  mirror_q[63:32] <= bus_wdata;
                end
              end else begin
                rdata_q <= rdata_d;
                // Freeze the high word alongside the low-word read
                if (sel_mt_lo) snap_q <= mtime_h;
              end
            end
          end
        end
        ST_RESP: begin
          state_q   <= ST_IDLE;
          ack_q     <= 1'b0;
          err_q     <= 1'b0;
          rdata_q   <= 32'h0;
          cmp_set_q <= 2'b00;
        end
      endcase
    end
  end

  assign bus_rdata    = rdata_q;
  assign bus_ack      = ack_q;
  assign bus_err      = err_q;
  assign mtimecmp_in  = cmp_in_q;
  assign mtimecmp_set = cmp_set_q;

endmodule
